// File: rtl/uart_tx_buffered_if.sv
// Byte write channel between the bus decode and the buffered UART transmitter.
// The master presents tx_data with tx_valid; the slave accepts with tx_ready.
interface uart_tx_buffered_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small FIFO absorbs bursts of byte writes,
// and a four-state serializer drains it onto a registered tx line.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   bus,
  output logic                tx_o,
  output logic                busy,
  output logic [FIFO_AW:0]    level
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int                BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  LVL_FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               push, pop, baud_end;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign bus.tx_ready = !rst && (level_q != LVL_FULL);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign baud_end     = (baud_q == BAUD_LAST);

  assign tx_o  = tx_q;
  assign level = level_q;
  assign busy  = (state_q != IDLE) || (level_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        // Last stop cycle chains straight into the next start bit when data is queued.
        if (baud_end) begin
          baud_d = '0;
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + FIFO_AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + FIFO_AW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
